// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-memory sequencer.
// Contents:
//   seq_state_e       controller state (IDLE / LOAD / RUN)
//   WORD_BYTES        bytes per instruction word (PC step)
//   DEFAULT_RESET_PC  default PC after reset and on starting RUN
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_e;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/imem_sequencer_pc_next_sel.sv
// Combinational next-PC priority mux for the RUN state.
// Ports:
//   pc_i             current PC
//   halt_i           leaving RUN: hold the PC
//   branch_taken_i   redirect request
//   branch_target_i  redirect byte address (forced to word alignment)
//   stall_i          hold PC
//   pc_next_o        selected next PC
// Priority: halt > branch > stall > sequential (+WORD_BYTES, modulo 2^32).
module pc_next_sel
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        halt_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    output logic [31:0] pc_next_o
);

    localparam logic [31:0] PC_STEP    = 32'(WORD_BYTES);
    localparam logic [31:0] ALIGN_MASK = ~(PC_STEP - 32'd1);

    always_comb begin
        pc_next_o = pc_i + PC_STEP;
        if (halt_i) begin
            pc_next_o = pc_i;
        end else if (branch_taken_i) begin
            // A redirect beats a simultaneous stall.
            pc_next_o = branch_target_i & ALIGN_MASK;
        end else if (stall_i) begin
            pc_next_o = pc_i;
        end
    end

endmodule

// File: rtl/imem_sequencer.sv
// Owner of the single instruction-memory port ahead of the fetch stage.
// After reset it either boot-loads a word stream into memory (valid/ready)
// or starts fetching directly; in RUN it sequences the PC with stall and
// branch-redirect support and tags each returned word with valid + PC.
// Ports:
//   Clk, Rst                      clock, synchronous active-high reset
//   LoadStart, RunStart, Halt     mode control
//   LoadData/LoadValid/LoadLast   load stream in, LoadReady out
//   MemAddr, MemWriteData,
//   MemWriteEnable                instruction-memory port (1-cycle read)
//   Stall, BranchTaken,
//   BranchTarget                  hazard-unit controls
//   InstrValid, InstrPC           tag for the memory read data this cycle
//   Running                       high while in RUN
module imem_sequencer
    import mips_fetch_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        LoadStart,
    input  logic        RunStart,
    input  logic        Halt,
    input  logic [31:0] LoadData,
    input  logic        LoadValid,
    input  logic        LoadLast,
    output logic        LoadReady,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    output logic        MemWriteEnable,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        InstrValid,
    output logic [31:0] InstrPC,
    output logic        Running
);

    // Wide enough to hold MEM_DEPTH itself after the final word.
    localparam int unsigned    CNT_W    = $clog2(MEM_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEM_DEPTH - 1);

    seq_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic             instr_valid_q, instr_valid_d;
    logic [31:0]      instr_pc_q, instr_pc_d;

    logic [31:0]      pc_run_next;
    logic             load_hs;
    logic             load_final;
    logic             fetch_ok;

    pc_next_sel u_pc_next_sel (
        .pc_i            (pc_q),
        .halt_i          (Halt),
        .branch_taken_i  (BranchTaken),
        .branch_target_i (BranchTarget),
        .stall_i         (Stall),
        .pc_next_o       (pc_run_next)
    );

    // Ready is masked during reset so a reset cycle never writes memory.
    assign LoadReady  = (state_q == ST_LOAD) && !Rst;
    assign load_hs    = LoadValid && LoadReady;
    assign load_final = load_hs && (LoadLast || (load_cnt_q == LAST_IDX));

    // A fetch survives to the next cycle only if issued in RUN with no
    // redirect, stall or halt in the issuing cycle.
    assign fetch_ok = (state_q == ST_RUN) && !Halt && !BranchTaken && !Stall;

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            load_cnt_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            load_cnt_q    <= load_cnt_d;
            instr_valid_q <= instr_valid_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (LoadStart) begin
                    state_d = ST_LOAD;
                end else if (RunStart) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_final) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        load_cnt_d = load_cnt_q;
        if ((state_q == ST_IDLE) && LoadStart) begin
            load_cnt_d = '0;
        end else if (load_hs) begin
            load_cnt_d = load_cnt_q + CNT_W'(1);
        end

        // Outside RUN the PC is parked at RESET_PC so every entry into RUN
        // (from IDLE or from the end of a load) starts there.
        pc_d = (state_q == ST_RUN) ? pc_run_next : RESET_PC;

        instr_valid_d = fetch_ok;
        instr_pc_d    = fetch_ok ? pc_q : instr_pc_q;
    end

    // Output logic
    always_comb begin
        MemAddr = 32'h0;
        case (state_q)
            ST_LOAD: MemAddr = 32'(load_cnt_q) << 2;
            ST_RUN:  MemAddr = pc_q;
            default: MemAddr = 32'h0;
        endcase
        MemWriteData   = LoadData;
        MemWriteEnable = load_hs;
        Running        = (state_q == ST_RUN);
        InstrValid     = instr_valid_q;
        InstrPC        = instr_pc_q;
    end

endmodule
